// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-based prefetch from a 1-cycle sync RAM
// into a small FIFO, with redirect flush and a sticky end-of-program halt.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_mem_instr [FIFO_DEPTH];
    logic [31:0] r_mem_pc    [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic        r_inflight;
    logic [31:0] r_infl_pc;
    logic        r_discard;
    logic [31:0] r_fetch_count;

    logic          w_empty;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_head_pc;
    logic          w_head_eof;
    logic          w_rsp_eof;
    logic [AW+1:0] w_occ;
    logic          w_credit;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_pop_adv;
    logic [1:0]    w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[1:0];

    assign w_empty      = (r_count == '0);
    assign w_head_instr = r_mem_instr[r_rptr];
    assign w_head_pc    = r_mem_pc[r_rptr];
    assign w_head_eof   = !w_empty && (w_head_instr == EOF_WORD);

    // An EOF response arriving now must not be followed by another read.
    assign w_rsp_eof = r_inflight && (imem_rdata == EOF_WORD);

    assign w_occ    = {1'b0, r_count} + {{(AW+1){1'b0}}, r_inflight};
    assign w_credit = (w_occ < (AW+2)'(FIFO_DEPTH));
    assign w_issue  = (r_state == S_RUN) && !redirect && w_credit && !w_rsp_eof;

    assign w_push    = r_inflight && !r_discard && !redirect;
    assign w_pop     = instr_valid && instr_ready && !redirect;
    assign w_pop_adv = w_pop && !w_head_eof;

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? 32'h0 : w_head_instr;
    assign instr_pc    = w_empty ? 32'h0 : w_head_pc;
    assign imem_addr   = {2'b00, r_fetch_pc[31:2]};
    assign fetch_count = r_fetch_count;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = S_RUN;
        end else if (w_push && (imem_rdata == EOF_WORD)) begin
            w_state_nxt = S_STOP;
        end
    end

    // Gating with rst keeps the strobe low while reset is asserted.
    always_comb begin
        imem_rd_en = w_issue && rst;
        halted     = (r_state == S_STOP) && w_head_eof;
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_infl_pc;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_infl_pc     <= 32'h0;
            r_discard     <= 1'b0;
            r_fetch_count <= 32'h0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_discard  <= r_inflight;
        end else begin
            r_inflight <= w_issue;
            // Only the slot right after a redirect can carry a stale word.
            r_discard  <= 1'b0;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_infl_pc  <= r_fetch_pc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_adv) begin
                r_rptr        <= r_rptr + AW'(1);
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop_adv);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirect,
// EOF halt and asynchronous reset, against a 1-cycle synchronous RAM.
module tb_instr_fetch_unit;

    logic        CLOCK_50;
    logic        rst;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    int          vectors;
    int          miscompares;
    int          n_rd;

    instr_fetch_unit #(
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0),
        .EOF_WORD  (32'hFFFF_FFFF)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        imem_rdata  = 32'h0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0010_0093 + k;

        #3;
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);

        // Streaming with ready held high
        instr_ready = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b1;
        #1;
        check("first_rd_en", {31'b0, imem_rd_en}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        @(negedge CLOCK_50);
        check("lat_valid", {31'b0, instr_valid}, 32'h0);
        @(negedge CLOCK_50);
        for (int k = 0; k < 8; k++) begin
            check("str_valid", {31'b0, instr_valid}, 32'h1);
            check("str_pc", instr_pc, 32'(4 * k));
            check("str_instr", instr, 32'h0010_0093 + 32'(k));
            check("str_count", fetch_count, 32'(k));
            @(negedge CLOCK_50);
        end
        check("str_count8", fetch_count, 32'd8);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", {31'b0, instr_valid}, 32'h0);
        check("ar_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("ar_count", fetch_count, 32'h0);
        check("ar_instr", instr, 32'h0);
        check("ar_pc", instr_pc, 32'h0);
        @(negedge CLOCK_50);
        rst = 1'b1;
        @(negedge CLOCK_50);
        check("ar_lat", {31'b0, instr_valid}, 32'h0);
        @(negedge CLOCK_50);
        check("ar_first_pc", instr_pc, 32'h0);
        check("ar_first_in", instr, 32'h0010_0093);

        // Backpressure: only FIFO_DEPTH reads may issue
        instr_ready = 1'b0;
        do_reset();
        n_rd = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imem_rd_en) n_rd++;
            @(negedge CLOCK_50);
        end
        check("bp_reads", 32'(n_rd), 32'd4);
        check("bp_rd_en", {31'b0, imem_rd_en}, 32'h0);
        check("bp_head_pc", instr_pc, 32'h0);
        check("bp_head_in", instr, 32'h0010_0093);
        check("bp_count", fetch_count, 32'h0);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("bp_valid", {31'b0, instr_valid}, 32'h1);
            check("bp_pc", instr_pc, 32'(4 * k));
            @(negedge CLOCK_50);
        end

        // Redirect while the pc=0x8 response is pending
        instr_ready = 1'b0;
        do_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rd_no_issue", {31'b0, imem_rd_en}, 32'h0);
        @(negedge CLOCK_50);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("rd_flushed", {31'b0, instr_valid}, 32'h0);
        check("rd_issue", {31'b0, imem_rd_en}, 32'h1);
        check("rd_addr", imem_addr, 32'h10);
        @(negedge CLOCK_50);
        check("rd_lat", {31'b0, instr_valid}, 32'h0);
        @(negedge CLOCK_50);
        check("rd_pc40", instr_pc, 32'h40);
        check("rd_in40", instr, 32'h0010_0093 + 32'd16);
        @(negedge CLOCK_50);
        check("rd_pc44", instr_pc, 32'h44);
        check("rd_cnt1", fetch_count, 32'd1);

        // Redirect and pop in the same cycle, unaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h13;
        @(negedge CLOCK_50);
        check("rp_count", fetch_count, 32'd1);
        check("rp_flushed", {31'b0, instr_valid}, 32'h0);
        redirect = 1'b0;
        #1;
        check("rp_addr", imem_addr, 32'h4);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rp_pc10", instr_pc, 32'h10);
        check("rp_in10", instr, 32'h0010_0097);

        // EOF at word 3
        mem[3] = 32'hFFFF_FFFF;
        instr_ready = 1'b1;
        do_reset();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("eof_pc0", instr_pc, 32'h0);
        @(negedge CLOCK_50);
        check("eof_pc4", instr_pc, 32'h4);
        @(negedge CLOCK_50);
        check("eof_pc8", instr_pc, 32'h8);
        check("eof_no_rd", {31'b0, imem_rd_en}, 32'h0);
        @(negedge CLOCK_50);
        for (int c = 0; c < 8; c++) begin
            check("eof_halted", {31'b0, halted}, 32'h1);
            check("eof_valid", {31'b0, instr_valid}, 32'h1);
            check("eof_instr", instr, 32'hFFFF_FFFF);
            check("eof_pc", instr_pc, 32'hC);
            check("eof_rd_en", {31'b0, imem_rd_en}, 32'h0);
            check("eof_count", fetch_count, 32'd3);
            @(negedge CLOCK_50);
        end

        // Redirect out of STOP resumes fetching
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        @(negedge CLOCK_50);
        redirect = 1'b0;
        check("rs_halted", {31'b0, halted}, 32'h0);
        check("rs_valid", {31'b0, instr_valid}, 32'h0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rs_pc20", instr_pc, 32'h20);
        check("rs_in20", instr, 32'h0010_0093 + 32'd8);
        check("rs_count", fetch_count, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
